mult_share_arb: RTL and testbench

- Round-robin arbiter that time-shares one signed fixed-point multiplier (Q(DWIDTH-FRAC).FRAC, truncating) among NREQ requesters, such as the sigmoid and neuron-accumulate units.
- Accepts at most one operand pair per cycle and runs a 2-stage pipeline: operand register, then product register.
- Returns each result tagged with the requester index, plus an overflow flag.

---
 rtl/mult_share_arb.sv | 131 +++++++++++++
 tb/tb_mult_share_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one signed fixed-point multiplier among NREQ requesters.
// Two-stage pipeline (operand register, product register); results are tagged with the requester index.
module mult_share_arb #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int NREQ   = 4,
    parameter int IDW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_a,
    input  logic [NREQ*DWIDTH-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [DWIDTH-1:0]      rsp_data,
    output logic                   rsp_ovf,
    output logic                   busy
);

    localparam int HIW = DWIDTH - FRAC + 1;

    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [NREQ-1:0]     gnt;
    logic                gnt_any;
    logic [IDW-1:0]      gnt_id;
    logic [IDW:0]        scan_sum;
    logic [IDW-1:0]      scan_idx;
    logic [DWIDTH-1:0]   gnt_a, gnt_b;

    logic [1:0]          vld_q;
    logic [DWIDTH-1:0]   s1_a_q, s1_b_q;
    logic [IDW-1:0]      s1_id_q;

    logic signed [2*DWIDTH-1:0] prod;
    logic [HIW-1:0]      prod_hi;
    logic                ovf_d;
    logic [NREQ-1:0]     id_oh;

    logic [NREQ-1:0]     rsp_valid_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [DWIDTH-1:0]   rsp_data_q;
    logic                rsp_ovf_q;

    // Scan ptr, ptr+1, ... wrapping at NREQ; the first valid requester wins.
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NREQ))
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            scan_idx = scan_sum[IDW-1:0];
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any       = 1'b1;
                gnt[scan_idx] = 1'b1;
                gnt_id        = scan_idx;
            end
        end
    end

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_a = req_a[i*DWIDTH +: DWIDTH];
                gnt_b = req_b[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any)
            ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end

    // Full-width signed product; the result window drops FRAC low bits (floor).
    assign prod    = $signed(s1_a_q) * $signed(s1_b_q);
    assign prod_hi = prod[2*DWIDTH-1 -: HIW];
    assign ovf_d   = !((&prod_hi) || !(|prod_hi));

    always_comb begin
        id_oh = '0;
        for (int i = 0; i < NREQ; i++)
            id_oh[i] = (s1_id_q == IDW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            vld_q       <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            vld_q[0] <= gnt_any;
            vld_q[1] <= vld_q[0];
            if (gnt_any) begin
                s1_a_q  <= gnt_a;
                s1_b_q  <= gnt_b;
                s1_id_q <= gnt_id;
            end
            rsp_valid_q <= vld_q[0] ? id_oh : '0;
            // Result fields hold their last value between responses.
            if (vld_q[0]) begin
                rsp_id_q   <= s1_id_q;
                rsp_data_q <= prod[FRAC +: DWIDTH];
                rsp_ovf_q  <= ovf_d;
            end
        end
    end

    assign req_ready = rst ? '0 : gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: stimulus pushes expected responses, a monitor pops and compares.
module tb_mult_share_arb;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_a, req_b;
    logic [NR-1:0]    req_ready, rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             rsp_ovf, busy;

    mult_share_arb #(.DWIDTH(DW), .FRAC(24), .NREQ(NR), .IDW(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          ovf;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid",   64'(rsp_valid), 64'(4'b0001 << mon_e.id));
                chk("rsp_id",      64'(rsp_id),    64'(mon_e.id));
                chk("rsp_data",    64'(rsp_data),  64'(mon_e.data));
                chk("rsp_ovf",     64'(rsp_ovf),   64'(mon_e.ovf));
                chk("rsp_latency", 64'(cyc),       64'(mon_e.due));
            end
        end
    end

    function automatic logic [IW-1:0] gid(input logic [NR-1:0] oh);
        gid = '0;
        for (int i = 0; i < NR; i++)
            if (oh[i]) gid = IW'(i);
    endfunction

    task automatic set_ops(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = a;
            req_b[i*DW +: DW] = b;
        end
    endtask

    // One cycle with the given valids; checks the grant and records the expected result.
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] exp_gnt,
                        input logic [DW-1:0] ed, input logic eo);
        exp_t e;
        req_valid = v;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_gnt));
        if (exp_gnt != '0) begin
            e.id   = gid(exp_gnt);
            e.data = ed;
            e.ovf  = eo;
            e.due  = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [NR-1:0] v, input logic [NR-1:0] exp_gnt,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] ed, input logic eo);
        set_ops(a, b);
        step(v, exp_gnt, ed, eo);
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 4'b1111;
        set_ops(32'h0100_0000, 32'h0100_0000);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id",    64'(rsp_id),    64'd0);
        chk("reset_rsp_data",  64'(rsp_data),  64'd0);
        chk("reset_rsp_ovf",   64'(rsp_ovf),   64'd0);
        chk("reset_busy",      64'(busy),      64'd0);
        @(posedge clk);
        #1;

        // Fairness from ptr=0; requester i multiplies (i+1.0) by 1.0.
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = 32'(i + 1) << 24;
            req_b[i*DW +: DW] = 32'h0100_0000;
        end
        for (int k = 0; k < 8; k++)
            step(4'b1111, 4'(1 << (k % 4)), 32'((k % 4) + 1) << 24, 1'b0);
        req_valid = '0;
        @(negedge clk); chk("busy_after_last+1", 64'(busy), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("busy_after_last+2", 64'(busy), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("busy_after_last+3", 64'(busy), 64'd0);
        @(posedge clk); #1;

        issue(4'b0001, 4'b0001, 32'h0180_0000, 32'h0200_0000, 32'h0300_0000, 1'b0);
        issue(4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0);
        idle(3);
        issue(4'b0100, 4'b0100, 32'hFF00_0000, 32'h0080_0000, 32'hFF80_0000, 1'b0);
        idle(2);
        issue(4'b1000, 4'b1000, 32'h6400_0000, 32'h0200_0000, 32'hC800_0000, 1'b1);
        idle(2);

        // Grant 1 sets ptr=2; then 1001 must go to 3 before 0.
        issue(4'b0010, 4'b0010, 32'h0040_0000, 32'hFFC0_0000, 32'hFFF0_0000, 1'b0);
        set_ops(32'hFFFF_FFFF, 32'h0080_0000);
        step(4'b1001, 4'b1000, 32'hFFFF_FFFF, 1'b0);
        step(4'b1001, 4'b0001, 32'hFFFF_FFFF, 1'b0);

        // Lone requester 3 accepted on three consecutive cycles.
        issue(4'b1000, 4'b1000, 32'h7FFF_FFFF, 32'h0100_0000, 32'h7FFF_FFFF, 1'b0);
        issue(4'b1000, 4'b1000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 1'b0);
        issue(4'b1000, 4'b1000, 32'hC000_0000, 32'h0010_0000, 32'hFC00_0000, 1'b0);
        issue(4'b0100, 4'b0100, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        idle(4);
        chk("sb_drained_before_reset", 64'(sb.size()), 64'd0);

        // Two ops in flight, then reset: neither may produce a response afterwards.
        set_ops(32'h0100_0000, 32'h0100_0000);
        req_valid = 4'b0001;
        @(negedge clk); chk("midrst_grant0", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(negedge clk); chk("midrst_grant1", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("post_reset_busy",      64'(busy),      64'd0);
            @(posedge clk); #1;
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
